// File: rtl/wb_stage_pkg.sv
// Shared writeback definitions: bus layout, CP0 register numbers,
// exception codes and CP0 write masks.
package wb_stage_pkg;

    localparam int MS_WS_W = 149;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    typedef struct packed {
        logic [31:0] rt_value;
        logic        eret;
        logic        bd;
        logic        mtc0_we;
        logic [4:0]  cp0_addr;
        logic        res_from_cp0;
        logic [31:0] badvaddr;
        logic        ex;
        logic [4:0]  excode;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } ms_ws_bus_t;

    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/wb_stage_cp0_regs.sv
// CP0 register file: Status, Cause, EPC, BadVAddr, Count, Compare.
// Ports: commit controls from writeback, read port, EPC, int_pending.
module cp0_regs
    import wb_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  logic        ex,
    input  logic        eret,
    input  logic        bd,
    input  logic        mtc0_we,
    input  logic [4:0]  addr,
    input  logic [4:0]  excode,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    input  logic [31:0] badvaddr,
    output logic [31:0] rdata,
    output logic [31:0] epc,
    output logic        int_pending
);

    logic [31:0] status, cause, epc_r, count, compare, badv;
    logic [31:0] status_n, cause_n, epc_n, count_n, compare_n, badv_n;
    logic        tick;
    logic        mtc0_go, ex_go, eret_go;

    // an exception on the same instruction kills its mtc0 and eret
    assign mtc0_go = valid && mtc0_we && !ex;
    assign ex_go   = valid && ex;
    assign eret_go = valid && eret && !ex;

    always_comb begin
        status_n  = status;
        cause_n   = cause;
        epc_n     = epc_r;
        count_n   = tick ? count + 32'd1 : count;
        compare_n = compare;
        badv_n    = badv;
        if (mtc0_go) begin
            case (addr)
                CP0_STATUS:   status_n  = (status & ~STATUS_WMASK)
                                        | (wdata & STATUS_WMASK);
                CP0_CAUSE:    cause_n   = (cause & ~CAUSE_WMASK)
                                        | (wdata & CAUSE_WMASK);
                CP0_EPC:      epc_n     = wdata;
                CP0_COUNT:    count_n   = wdata;
                CP0_COMPARE:  compare_n = wdata;
                CP0_BADVADDR: badv_n    = wdata;
                default:      ;
            endcase
        end
        if (ex_go) begin
            status_n[1] = 1'b1;
            // nested exceptions keep the original EPC and BD
            if (!status[1]) begin
                epc_n     = bd ? pc - 32'd4 : pc;
                cause_n[31] = bd;
            end
            cause_n[6:2] = excode;
            if (is_addr_exc(excode))
                badv_n = badvaddr;
        end
        if (eret_go)
            status_n[1] = 1'b0;
        if (count_n == compare_n) begin
            cause_n[30] = 1'b1;
            cause_n[15] = 1'b1;
        end
        // writing Compare acknowledges the timer, even on a new match
        if (mtc0_go && addr == CP0_COMPARE) begin
            cause_n[30] = 1'b0;
            cause_n[15] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status  <= STATUS_RESET;
            cause   <= '0;
            epc_r   <= '0;
            count   <= '0;
            compare <= '0;
            badv    <= '0;
            tick    <= 1'b0;
        end else begin
            status  <= status_n;
            cause   <= cause_n;
            epc_r   <= epc_n;
            count   <= count_n;
            compare <= compare_n;
            badv    <= badv_n;
            tick    <= ~tick;
        end
    end

    always_comb begin
        case (addr)
            CP0_BADVADDR: rdata = badv;
            CP0_COUNT:    rdata = count;
            CP0_COMPARE:  rdata = compare;
            CP0_STATUS:   rdata = status;
            CP0_CAUSE:    rdata = cause;
            CP0_EPC:      rdata = epc_r;
            default:      rdata = '0;
        endcase
    end

    assign epc = epc_r;
    assign int_pending = (|(cause[15:8] & status[15:8]))
                       && status[0] && !status[1];

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: pipeline register, regfile write, bypass, flush.
// Ports: memory-stage handshake/bus, regfile port, flush, trace.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int          MS_TO_WS_BUS_WD = MS_WS_W,
    parameter logic [31:0] EX_VECTOR       = 32'hBFC0_0380
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ms_to_ws_valid,
    input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic                       ws_allowin,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [31:0]                rf_wdata,
    output logic [37:0]                ws_forward_bus,
    output logic                       ex_from_ws,
    output logic [31:0]                flush_pc,
    output logic                       int_pending,
    output logic [31:0]                debug_wb_pc,
    output logic [3:0]                 debug_wb_rf_wen,
    output logic [4:0]                 debug_wb_rf_wnum,
    output logic [31:0]                debug_wb_rf_wdata
);

    logic                       ws_valid;
    logic                       ws_ready_go;
    logic [MS_TO_WS_BUS_WD-1:0] bus_r;
    ms_ws_bus_t                 b;
    logic [31:0]                cp0_rdata, epc, wdata;

    assign b           = bus_r;
    assign ws_ready_go = 1'b1;
    assign ws_allowin  = !ws_valid || ws_ready_go;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            ws_valid <= 1'b0;
        else if (ws_allowin)
            ws_valid <= ms_to_ws_valid;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            bus_r <= '0;
        else if (ms_to_ws_valid && ws_allowin)
            bus_r <= ms_to_ws_bus;
    end

    cp0_regs u_cp0 (
        .clk         (clk),
        .resetn      (resetn),
        .valid       (ws_valid),
        .ex          (b.ex),
        .eret        (b.eret),
        .bd          (b.bd),
        .mtc0_we     (b.mtc0_we),
        .addr        (b.cp0_addr),
        .excode      (b.excode),
        .wdata       (b.rt_value),
        .pc          (b.pc),
        .badvaddr    (b.badvaddr),
        .rdata       (cp0_rdata),
        .epc         (epc),
        .int_pending (int_pending)
    );

    assign wdata      = b.res_from_cp0 ? cp0_rdata : b.result;
    assign rf_we      = ws_valid && b.gr_we && !b.ex;
    assign rf_waddr   = b.dest;
    assign rf_wdata   = wdata;
    assign ex_from_ws = ws_valid && (b.ex || b.eret);
    // the vector is the idle value so reset shows EX_VECTOR
    assign flush_pc   = (ws_valid && b.eret && !b.ex) ? epc : EX_VECTOR;

    assign ws_forward_bus    = {ws_valid & b.gr_we, b.dest, wdata};
    assign debug_wb_pc       = b.pc;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = b.dest;
    assign debug_wb_rf_wdata = wdata;

endmodule
